turn_controller: RTL and testbench

Game-turn sequencer for the card-match HUD. It sits directly upstream of the seven-segment HUD stage and produces every value that stage displays: both player scores, the active player, the per-turn countdown and the winner. It consumes pair-reveal results from the board logic and runs a one-second prescaler from the system clock. It also enforces turn timeouts and detects game end.

---
 rtl/turn_controller_if.sv | 22 ++
 rtl/turn_controller.sv | 91 +++++++++
 tb/tb_turn_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/turn_controller_if.sv
// turn_controller_if: game-control inputs and HUD-facing outputs of the turn sequencer
interface turn_controller_if;
  logic       start;
  logic       pair_valid;
  logic       pair_match;
  logic       pause;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [3:0] timer;
  logic       player;
  logic [1:0] winner;
  logic       game_over;
  logic       turn_timeout;
  modport master (
    output start, pair_valid, pair_match, pause,
    input  p1_score, p2_score, timer, player, winner, game_over, turn_timeout
  );
  modport slave (
    input  start, pair_valid, pair_match, pause,
    output p1_score, p2_score, timer, player, winner, game_over, turn_timeout
  );
endinterface

// File: rtl/turn_controller.sv
// turn_controller: card-match turn sequencer with scores, per-turn countdown, timeouts and winner
module turn_controller #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_SECONDS  = 15,
  parameter int TOTAL_PAIRS   = 8
) (
  input logic              clock_i,
  input logic              reset_n_i,
  turn_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [3:0] TS = 4'(TURN_SECONDS);
  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    p1_q, p1_d, p2_q, p2_d, timer_q, timer_d, pairs_q, pairs_d;
  logic          player_q, player_d, timeout_q, timeout_d;
  logic [1:0]    winner_q, winner_d;
  logic          play, tick, pv, done;
  assign play = state_q == PLAY;
  assign tick = play && !bus.pause && pre_q == PW'(TICKS_PER_SEC - 1);
  assign pv   = play && bus.pair_valid;
  assign done = pv && bus.pair_match && pairs_q + 4'd1 == 4'(TOTAL_PAIRS);
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      timer_q   <= TS;
      pairs_q   <= '0;
      player_q  <= 1'b0;
      timeout_q <= 1'b0;
      winner_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      timer_q   <= timer_d;
      pairs_q   <= pairs_d;
      player_q  <= player_d;
      timeout_q <= timeout_d;
      winner_q  <= winner_d;
    end
  always_comb state_d = bus.start ? PLAY : done ? OVER : state_q;
  // a pair event overrides a coincident tick, so the tick branch is only reached without one
  always_comb begin
    pre_d     = pre_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    timer_d   = timer_q;
    pairs_d   = pairs_q;
    player_d  = player_q;
    timeout_d = 1'b0;
    winner_d  = winner_q;
    if (bus.start) begin
      pre_d    = '0;
      p1_d     = '0;
      p2_d     = '0;
      timer_d  = TS;
      pairs_d  = '0;
      player_d = 1'b0;
      winner_d = 2'b00;
    end else if (pv) begin
      pre_d   = '0;
      timer_d = TS;
      if (bus.pair_match) begin
        p1_d    = !player_q && p1_q != 4'hf ? p1_q + 4'd1 : p1_q;
        p2_d    = player_q && p2_q != 4'hf ? p2_q + 4'd1 : p2_q;
        pairs_d = pairs_q + 4'd1;
      end else
        player_d = !player_q;
      if (done) winner_d = p1_d > p2_d ? 2'b01 : p2_d > p1_d ? 2'b10 : 2'b11;
    end else if (play && !bus.pause) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        timer_d   = timer_q > 4'd1 ? timer_q - 4'd1 : TS;
        player_d  = timer_q == 4'd1 ? !player_q : player_q;
        timeout_d = timer_q == 4'd1;
      end
    end
  end
  assign bus.p1_score     = p1_q;
  assign bus.p2_score     = p2_q;
  assign bus.timer        = timer_q;
  assign bus.player       = player_q;
  assign bus.winner       = winner_q;
  assign bus.game_over    = state_q == OVER;
  assign bus.turn_timeout = timeout_q;
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed checks of countdown, pairs, pause, collisions, game end and async reset
module tb_turn_controller;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int n = 0;
  int nf = 0;
  turn_controller_if bus();
  turn_controller #(.TICKS_PER_SEC(4), .TURN_SECONDS(15), .TOTAL_PAIRS(8)) dut (
    .clock_i(clock), .reset_n_i(reset_n), .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic step(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask
  task automatic pair(input logic m);
    bus.pair_valid = 1'b1;
    bus.pair_match = m;
    step(1);
    bus.pair_valid = 1'b0;
    bus.pair_match = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_p1"}, 32'(bus.p1_score), 0);
    chk({tag, "_p2"}, 32'(bus.p2_score), 0);
    chk({tag, "_timer"}, 32'(bus.timer), 15);
    chk({tag, "_player"}, 32'(bus.player), 0);
    chk({tag, "_winner"}, 32'(bus.winner), 0);
    chk({tag, "_over"}, 32'(bus.game_over), 0);
    chk({tag, "_tmo"}, 32'(bus.turn_timeout), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.pair_valid = 1'b0;
    bus.pair_match = 1'b0;
    bus.pause = 1'b0;
    step(2);
    chk_reset("rst");
    reset_n = 1'b1;
    step(1);
    // 1: countdown and timeout
    pulse_start();
    chk("c_t15", 32'(bus.timer), 15);
    step(3);
    chk("c_t15b", 32'(bus.timer), 15);
    step(1);
    chk("c_t14", 32'(bus.timer), 14);
    step(52);
    chk("c_t1", 32'(bus.timer), 1);
    step(3);
    chk("c_tmo0", 32'(bus.turn_timeout), 0);
    step(1);
    chk("c_tmo1", 32'(bus.turn_timeout), 1);
    chk("c_ply1", 32'(bus.player), 1);
    chk("c_reload", 32'(bus.timer), 15);
    step(1);
    chk("c_tmo_once", 32'(bus.turn_timeout), 0);
    // 2: match at edge 10
    pulse_start();
    step(9);
    chk("m_t13", 32'(bus.timer), 13);
    pair(1'b1);
    chk("m_p1", 32'(bus.p1_score), 1);
    chk("m_t15", 32'(bus.timer), 15);
    chk("m_ply", 32'(bus.player), 0);
    step(3);
    chk("m_hold", 32'(bus.timer), 15);
    step(1);
    chk("m_dec", 32'(bus.timer), 14);
    // 3: mismatch and pause
    pulse_start();
    pair(1'b0);
    chk("p_ply1", 32'(bus.player), 1);
    chk("p_t15", 32'(bus.timer), 15);
    bus.pause = 1'b1;
    step(20);
    chk("p_frozen", 32'(bus.timer), 15);
    pair(1'b0);
    chk("p_ply0", 32'(bus.player), 0);
    step(2);
    bus.pause = 1'b0;
    step(2);
    bus.pause = 1'b1;
    step(10);
    chk("p_hold2", 32'(bus.timer), 15);
    bus.pause = 1'b0;
    step(1);
    chk("p_pre_kept", 32'(bus.timer), 15);
    step(1);
    chk("p_dec", 32'(bus.timer), 14);
    // 4: pair collides with the timeout tick
    pulse_start();
    step(59);
    chk("x_t1", 32'(bus.timer), 1);
    pair(1'b0);
    chk("x_ply", 32'(bus.player), 1);
    chk("x_tmo", 32'(bus.turn_timeout), 0);
    chk("x_t15", 32'(bus.timer), 15);
    step(1);
    chk("x_tmo_after", 32'(bus.turn_timeout), 0);
    chk("x_ply_after", 32'(bus.player), 1);
    // 5: game end 5-3
    pulse_start();
    repeat (5) begin pair(1'b1); step(1); end
    pair(1'b0);
    step(1);
    repeat (2) begin pair(1'b1); step(1); end
    pair(1'b1);
    chk("g_over", 32'(bus.game_over), 1);
    chk("g_win", 32'(bus.winner), 1);
    chk("g_p1", 32'(bus.p1_score), 5);
    chk("g_p2", 32'(bus.p2_score), 3);
    pair(1'b1);
    step(10);
    chk("g_p2_frozen", 32'(bus.p2_score), 3);
    chk("g_t_frozen", 32'(bus.timer), 15);
    chk("g_ply_frozen", 32'(bus.player), 1);
    chk("g_over_hold", 32'(bus.game_over), 1);
    pulse_start();
    repeat (4) begin pair(1'b1); step(1); end
    pair(1'b0);
    repeat (4) pair(1'b1);
    chk("g_tie", 32'(bus.winner), 3);
    chk("g_tie_over", 32'(bus.game_over), 1);
    pulse_start();
    chk_reset("g_restart");
    step(4);
    chk("g_play", 32'(bus.timer), 14);
    // 6: async reset mid-turn
    pulse_start();
    repeat (3) pair(1'b1);
    step(32);
    chk("r_p1", 32'(bus.p1_score), 3);
    chk("r_t7", 32'(bus.timer), 7);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("r_async");
    step(3);
    chk_reset("r_held");
    reset_n = 1'b1;
    step(2);
    pair(1'b1);
    step(8);
    chk_reset("r_idle");
    pulse_start();
    step(4);
    chk("r_play", 32'(bus.timer), 14);
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
